// File: rtl/lcd_spi_writer.sv
// Shifts one 9-bit {dc, payload} word out over 4-wire SPI (mode 0, MSB first), then pulses wr_done.
// Optional macro LCD_SPI_CS_KEEP_EN holds lcd_cs_n low across a continuous en_write burst.
module lcd_spi_writer #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi
);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : gen_bad_clk_div
        $error("lcd_spi_writer: CLK_DIV must be 1..255");
    end
    if (GAP_CYCLES < 2) begin : gen_bad_gap
        $error("lcd_spi_writer: GAP_CYCLES must be >= 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [6:0]      shadow_q, shadow_d;
    logic            wr_done_q, wr_done_d;
    logic            busy_q, busy_d;
    logic            cs_n_q, cs_n_d;
    logic            dc_q, dc_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;

    logic tick;
    logic fall_tick;
    logic gap_last;
    logic capture;

    assign tick      = (div_q == 8'(CLK_DIV - 1));
    assign fall_tick = tick && sclk_q;
    assign gap_last  = (gap_q == GapW'(GAP_CYCLES - 1));
    // A GAP ending with en_write still high captures straight away for back-to-back bursts.
    assign capture   = en_write && ((state_q == StIdle) || ((state_q == StGap) && gap_last));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= StIdle;
            div_q     <= 8'd0;
            bit_q     <= 3'd0;
            gap_q     <= '0;
            shadow_q  <= 7'd0;
            wr_done_q <= 1'b0;
            busy_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            dc_q      <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            shadow_q  <= shadow_d;
            wr_done_q <= wr_done_d;
            busy_q    <= busy_d;
            cs_n_q    <= cs_n_d;
            dc_q      <= dc_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = 8'd0;
        bit_d    = bit_q;
        gap_d    = '0;
        shadow_d = shadow_q;
        case (state_q)
            StIdle: begin
                if (en_write) state_d = StSetup;
            end
            StSetup: begin
                div_d = tick ? 8'd0 : div_q + 8'd1;
                if (tick) state_d = StShift;
            end
            StShift: begin
                div_d = tick ? 8'd0 : div_q + 8'd1;
                if (fall_tick) begin
                    // 3-bit counter wraps 7 -> 0 on the last falling tick, ending the word.
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StHold;
                    end else begin
                        shadow_d = {shadow_q[5:0], 1'b0};
                    end
                end
            end
            StHold: begin
                div_d = tick ? 8'd0 : div_q + 8'd1;
                if (tick) state_d = StDone;
            end
            StDone: begin
                state_d = StGap;
            end
            StGap: begin
                gap_d = gap_q + GapW'(1);
                if (gap_last) begin
                    gap_d   = '0;
                    state_d = en_write ? StSetup : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (capture) begin
            shadow_d = data[6:0];
            bit_d    = 3'd0;
        end
    end

    always_comb begin
        wr_done_d = 1'b0;
        busy_d    = busy_q;
        cs_n_d    = cs_n_q;
        dc_d      = dc_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        if (capture) begin
            busy_d = 1'b1;
            cs_n_d = 1'b0;
            dc_d   = data[8];
            mosi_d = data[7];
            sclk_d = 1'b0;
        end else begin
            case (state_q)
                StShift: begin
                    if (tick) begin
                        sclk_d = ~sclk_q;
                        if (sclk_q && bit_q != 3'd7) mosi_d = shadow_q[6];
                    end
                end
                StHold: begin
                    if (tick) begin
                        wr_done_d = 1'b1;
                        mosi_d    = 1'b0;
`ifdef LCD_SPI_CS_KEEP_EN
                        cs_n_d    = cs_n_q;
`else
                        cs_n_d    = 1'b1;
`endif
                    end
                end
                StGap: begin
                    if (gap_last) begin
                        busy_d = 1'b0;
                        cs_n_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wr_done  = wr_done_q;
    assign busy     = busy_q;
    assign lcd_cs_n = cs_n_q;
    assign lcd_dc   = dc_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;

    a_done_only_in_done : assert property (
        @(posedge sys_clk) disable iff (!sys_rst_n) wr_done_q |-> (state_q == StDone));
    a_idle_when_not_busy : assert property (
        @(posedge sys_clk) disable iff (!sys_rst_n) !busy_q |-> (state_q == StIdle));

endmodule
